// File: rtl/reg_wb_scheduler.sv
// Register-file write-port scheduler: round-robin arbitration among writeback
// requesters, a one-cycle registered write stage and a 32-entry busy scoreboard.
module reg_wb_scheduler #(
  parameter int N_REQ     = 3,
  parameter bit ZERO_LOCK = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [5*N_REQ-1:0]  req_idx,
  input  logic [32*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rf_rw,
  output logic [4:0]          rf_write_idx,
  output logic [31:0]         rf_input_data,
  input  logic                mark_valid,
  input  logic [4:0]          mark_idx,
  output logic                mark_ready,
  input  logic [4:0]          rd0_idx,
  input  logic [4:0]          rd1_idx,
  output logic                rd_stall,
  output logic [31:0]         busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] cand;
  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic             transfer;
  logic             write_en;
  logic             mark_set;
  logic [4:0]       sel_idx;
  logic [31:0]      sel_data;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;
  logic [31:0]      busy_next;

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

  // Grant qualification, selected payload and scoreboard next state.
  always_comb begin
    req_ready  = reset ? '0 : grant;
    transfer   = grant_any & ~reset;
    sel_idx    = req_idx[5*int'(grant_idx) +: 5];
    sel_data   = req_data[32*int'(grant_idx) +: 32];
    // Index-0 writes are consumed but never reach the register file.
    write_en   = transfer & ~(ZERO_LOCK & (sel_idx == 5'd0));
    ptr_next   = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
    mark_ready = ~busy[mark_idx];
    mark_set   = mark_valid & mark_ready & ((mark_idx != 5'd0) | ~ZERO_LOCK);
    set_mask   = mark_set ? (32'd1 << mark_idx) : 32'd0;
    clr_mask   = rf_rw ? (32'd1 << rf_write_idx) : 32'd0;
    // Set after clear so a new producer on the committing index keeps it busy.
    busy_next  = (busy & ~clr_mask) | set_mask;
    rd_stall   = busy[rd0_idx] | busy[rd1_idx];
  end

  // Pointer, write stage and scoreboard registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr        <= '0;
      rf_rw         <= 1'b0;
      rf_write_idx  <= 5'd0;
      rf_input_data <= 32'd0;
      busy          <= 32'd0;
    end else begin
      rr_ptr <= transfer ? ptr_next : rr_ptr;
      rf_rw  <= write_en;
      if (transfer) begin
        rf_write_idx  <= sel_idx;
        rf_input_data <= sel_data;
      end else begin
        rf_write_idx  <= rf_write_idx;
        rf_input_data <= rf_input_data;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Self-checking bench for reg_wb_scheduler: a behavioural model pushes expected
// write-stage/scoreboard state per edge; each test pops and compares after the edge.
module tb_reg_wb_scheduler;

  localparam int N = 3;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [5*N-1:0] req_idx;
  logic [32*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rf_rw;
  logic [4:0]     rf_write_idx;
  logic [31:0]    rf_input_data;
  logic           mark_valid;
  logic [4:0]     mark_idx;
  logic           mark_ready;
  logic [4:0]     rd0_idx;
  logic [4:0]     rd1_idx;
  logic           rd_stall;
  logic [31:0]    busy;

  reg_wb_scheduler #(.N_REQ(N), .ZERO_LOCK(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_idx(req_idx), .req_data(req_data), .req_ready(req_ready),
    .rf_rw(rf_rw), .rf_write_idx(rf_write_idx), .rf_input_data(rf_input_data),
    .mark_valid(mark_valid), .mark_idx(mark_idx), .mark_ready(mark_ready),
    .rd0_idx(rd0_idx), .rd1_idx(rd1_idx), .rd_stall(rd_stall), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rw;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [31:0] busy;
  } exp_t;

  exp_t sb[$];
  exp_t ex;
  int passed = 0;
  int total  = 0;

  int          m_ptr;
  logic        m_rw;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  logic [N-1:0] e_grant;
  logic        e_mready;
  logic        e_stall;

  task automatic model_reset();
    m_ptr = 0; m_rw = 1'b0; m_idx = 5'd0; m_data = 32'd0; m_busy = 32'd0;
    sb.delete();
  endtask

  // Reference behaviour for one edge: pre-edge outputs, then post-edge state pushed.
  task automatic model_step();
    logic [31:0] nb;
    exp_t e;
    int gi;
    int c;
    gi = -1;
    e_grant = '0;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (gi < 0 && req_valid[c]) gi = c;
    end
    if (gi >= 0) e_grant[gi] = 1'b1;
    e_mready = ~m_busy[mark_idx];
    e_stall  = m_busy[rd0_idx] | m_busy[rd1_idx];
    nb = m_busy;
    if (m_rw) nb[m_idx] = 1'b0;
    if (mark_valid && e_mready && mark_idx != 5'd0) nb[mark_idx] = 1'b1;
    if (gi >= 0) begin
      m_idx  = req_idx[5*gi +: 5];
      m_data = req_data[32*gi +: 32];
      m_rw   = (m_idx != 5'd0);
      m_ptr  = (gi + 1) % N;
    end else begin
      m_rw = 1'b0;
    end
    m_busy = nb;
    e.rw = m_rw; e.idx = m_idx; e.data = m_data; e.busy = m_busy;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] ix, input logic [31:0] d);
    req_valid[i]       = v;
    req_idx[5*i +: 5]  = ix;
    req_data[32*i +: 32] = d;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_idx = '0; req_data = '0;
    mark_valid = 1'b0; mark_idx = 5'd0; rd0_idx = 5'd0; rd1_idx = 5'd0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    req_valid = 3'b111;
    #1;
    total++; if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", req_ready); else passed++;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({rf_rw, rf_write_idx, rf_input_data, busy} !== {1'b0, 5'd0, 32'd0, 32'd0})
      $display("FAIL reset_state: got rw=%b idx=%0d data=%h busy=%h want all 0", rf_rw, rf_write_idx, rf_input_data, busy);
    else passed++;
    reset = 1'b0;
    req_valid = '0;
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] tbl [4];
    tbl[0] = 3'b001; tbl[1] = 3'b010; tbl[2] = 3'b100; tbl[3] = 3'b001;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i));
    for (int c = 0; c < 4; c++) begin
      #1;
      model_step();
      total++; if (req_ready !== tbl[c]) $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, tbl[c]); else passed++;
      @(posedge clock); #1;
      ex = sb.pop_front();
      total++;
      if ({rf_rw, rf_write_idx, rf_input_data, busy} !== ex || rf_rw !== 1'b1)
        $display("FAIL rr_write c%0d: got rw=%b idx=%0d data=%h busy=%h want %p", c, rf_rw, rf_write_idx, rf_input_data, busy, ex);
      else passed++;
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    int cnt [N];
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(20 + i), 32'hB000_0000 + 32'(i));
    for (int c = 0; c < 3 * N; c++) begin
      #1;
      model_step();
      for (int i = 0; i < N; i++) if (req_ready[i]) cnt[i]++;
      total++; if (req_ready !== e_grant) $display("FAIL b2b_grant c%0d: got %b want %b", c, req_ready, e_grant); else passed++;
      @(posedge clock); #1;
      ex = sb.pop_front();
      total++;
      if ({rf_rw, rf_write_idx, rf_input_data, busy} !== ex || rf_rw !== 1'b1)
        $display("FAIL b2b_write c%0d: got rw=%b idx=%0d data=%h want %p", c, rf_rw, rf_write_idx, rf_input_data, ex);
      else passed++;
    end
    for (int i = 0; i < N; i++) begin
      total++; if (cnt[i] != 3) $display("FAIL b2b_fair r%0d: got %0d grants want 3", i, cnt[i]); else passed++;
    end
    req_valid = '0;
  endtask

  task automatic test_single_write();
    clear_inputs();
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    model_step();
    total++; if (req_ready !== 3'b010) $display("FAIL single_grant: got %b want 010", req_ready); else passed++;
    @(posedge clock); #1;
    ex = sb.pop_front();
    total++;
    if ({rf_rw, rf_write_idx, rf_input_data} !== {1'b1, 5'd5, 32'hDEADBEEF} || {rf_rw, rf_write_idx, rf_input_data, busy} !== ex)
      $display("FAIL single_write: got rw=%b idx=%0d data=%h want rw=1 idx=5 data=deadbeef", rf_rw, rf_write_idx, rf_input_data);
    else passed++;
    req_valid = '0;
    #1;
    model_step();
    total++; if (req_ready !== 3'b000) $display("FAIL single_idle_ready: got %b want 000", req_ready); else passed++;
    @(posedge clock); #1;
    ex = sb.pop_front();
    total++;
    if (rf_rw !== 1'b0 || {rf_rw, rf_write_idx, rf_input_data, busy} !== ex)
      $display("FAIL single_idle: got rw=%b idx=%0d data=%h want rw=0 idx=5 data=deadbeef", rf_rw, rf_write_idx, rf_input_data);
    else passed++;
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    mark_valid = 1'b1; mark_idx = 5'd7;
    #1;
    model_step();
    total++; if (mark_ready !== 1'b1) $display("FAIL sb_mark_ready: got %b want 1", mark_ready); else passed++;
    @(posedge clock); #1;
    ex = sb.pop_front();
    total++; if (busy[7] !== 1'b1 || busy !== ex.busy) $display("FAIL sb_mark7: got busy=%h want %h", busy, ex.busy); else passed++;
    mark_valid = 1'b0; rd0_idx = 5'd7; rd1_idx = 5'd3;
    set_req(2, 1'b1, 5'd7, 32'h0000_0077);
    #1;
    total++; if (rd_stall !== 1'b1) $display("FAIL sb_stall7: got %b want 1", rd_stall); else passed++;
    model_step();
    @(posedge clock); #1;
    ex = sb.pop_front();
    total++;
    if (busy[7] !== 1'b1 || {rf_rw, rf_write_idx, rf_input_data, busy} !== ex)
      $display("FAIL sb_write_edge: got rw=%b idx=%0d busy=%h want rw=1 idx=7 busy[7]=1", rf_rw, rf_write_idx, busy);
    else passed++;
    req_valid = '0;
    #1;
    total++; if (rd_stall !== 1'b1) $display("FAIL sb_stall_commit: got %b want 1", rd_stall); else passed++;
    model_step();
    @(posedge clock); #1;
    ex = sb.pop_front();
    total++; if (busy[7] !== 1'b0 || busy !== ex.busy) $display("FAIL sb_clear7: got busy=%h want %h", busy, ex.busy); else passed++;
    total++; if (rd_stall !== 1'b0) $display("FAIL sb_unstall: got %b want 0", rd_stall); else passed++;
  endtask

  task automatic test_set_clear_same();
    clear_inputs();
    set_req(0, 1'b1, 5'd9, 32'h0000_0009);
    #1;
    model_step();
    @(posedge clock); #1;
    ex = sb.pop_front();
    total++; if (rf_rw !== 1'b1 || rf_write_idx !== 5'd9 || busy[9] !== 1'b0) $display("FAIL sc_write9: got rw=%b idx=%0d busy9=%b want 1/9/0", rf_rw, rf_write_idx, busy[9]); else passed++;
    req_valid = '0; mark_valid = 1'b1; mark_idx = 5'd9;
    #1;
    model_step();
    total++; if (mark_ready !== 1'b1) $display("FAIL sc_mark_ready: got %b want 1", mark_ready); else passed++;
    @(posedge clock); #1;
    ex = sb.pop_front();
    total++; if (busy[9] !== 1'b1 || busy !== ex.busy) $display("FAIL sc_set_wins: got busy=%h want %h", busy, ex.busy); else passed++;
    #1;
    model_step();
    total++; if (mark_ready !== 1'b0) $display("FAIL sc_waw: got mark_ready=%b want 0", mark_ready); else passed++;
    @(posedge clock); #1;
    ex = sb.pop_front();
    total++; if (busy[9] !== 1'b1 || busy !== ex.busy) $display("FAIL sc_ignored: got busy=%h want %h", busy, ex.busy); else passed++;
    mark_valid = 1'b0;
  endtask

  task automatic test_zero_lock();
    clear_inputs();
    set_req(0, 1'b1, 5'd0, 32'h0000_1234);
    mark_valid = 1'b1; mark_idx = 5'd0;
    #1;
    model_step();
    total++; if (req_ready !== 3'b001 || mark_ready !== 1'b1) $display("FAIL zl_ready: got ready=%b mark_ready=%b want 001/1", req_ready, mark_ready); else passed++;
    @(posedge clock); #1;
    ex = sb.pop_front();
    total++;
    if (rf_rw !== 1'b0 || busy[0] !== 1'b0 || {rf_rw, rf_write_idx, rf_input_data, busy} !== ex)
      $display("FAIL zl_write: got rw=%b busy=%h want rw=0 busy=%h", rf_rw, busy, ex.busy);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      clear_inputs();
      for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom());
      mark_valid = 1'($urandom_range(1, 0));
      mark_idx   = 5'($urandom_range(31, 0));
      rd0_idx    = 5'($urandom_range(31, 0));
      rd1_idx    = 5'($urandom_range(31, 0));
      #1;
      model_step();
      total++;
      if ({req_ready, mark_ready, rd_stall} !== {e_grant, e_mready, e_stall})
        $display("FAIL rnd_comb c%0d: got ready=%b mr=%b st=%b want %b/%b/%b", c, req_ready, mark_ready, rd_stall, e_grant, e_mready, e_stall);
      else passed++;
      @(posedge clock); #1;
      ex = sb.pop_front();
      total++;
      if ({rf_rw, rf_write_idx, rf_input_data, busy} !== ex)
        $display("FAIL rnd_write c%0d: got rw=%b idx=%0d data=%h busy=%h want %p", c, rf_rw, rf_write_idx, rf_input_data, busy, ex);
      else passed++;
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    set_req(0, 1'b1, 5'd3, 32'h0000_0333);
    mark_valid = 1'b1; mark_idx = 5'd4;
    #1;
    model_step();
    total++; if (req_ready !== 3'b001) $display("FAIL rm_grant: got %b want 001", req_ready); else passed++;
    @(posedge clock); #1;
    ex = sb.pop_front();
    total++; if ({rf_rw, rf_write_idx, rf_input_data, busy} !== ex) $display("FAIL rm_write: got rw=%b busy=%h want %p", rf_rw, busy, ex); else passed++;
    clear_inputs();
    reset = 1'b1;
    req_valid = 3'b111;
    #1;
    total++; if (req_ready !== 3'b000) $display("FAIL rm_reset_ready: got %b want 000", req_ready); else passed++;
    @(posedge clock); #1;
    total++; if (rf_rw !== 1'b0 || busy !== 32'd0) $display("FAIL rm_reset_state: got rw=%b busy=%h want 0/0", rf_rw, busy); else passed++;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(1 + i), 32'hC000_0000 + 32'(i));
    #1;
    model_step();
    total++; if (req_ready !== 3'b001) $display("FAIL rm_restart: got %b want 001", req_ready); else passed++;
    @(posedge clock); #1;
    ex = sb.pop_front();
    total++; if ({rf_rw, rf_write_idx, rf_input_data, busy} !== ex) $display("FAIL rm_restart_write: got rw=%b idx=%0d want %p", rf_rw, rf_write_idx, ex); else passed++;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_single_write();
    test_scoreboard();
    test_set_clear_same();
    test_zero_lock();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
